fw_wishbone_sram_ctrl_amo: RTL and testbench

Parametrised successor of the single-port Wishbone-to-SRAM controller: a Wishbone target that drives one byte-enabled synchronous SRAM. Adds configurable data width and SRAM read latency, an address range check with `t_err`, abort on `t_cyc` drop, and AMO read-modify-write that returns the old memory value. It sits between the system interconnect and a generic byte-enable SRAM macro.

---
 rtl/fw_wishbone_sram_ctrl_pkg.sv | 31 +++
 rtl/fw_wishbone_amo_alu.sv | 36 +++
 rtl/fw_wishbone_sram_ctrl_amo.sv | 160 ++++++++++++++++
 tb/tb_fw_wishbone_sram_ctrl_amo.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fw_wishbone_sram_ctrl_pkg.sv
// Shared types and AMO opcodes for the Wishbone SRAM controller.
// amo_supported() tells legal read-modify-write codes from reserved ones.
package fw_wishbone_sram_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    RWAIT,
    AMO_WB,
    WRITE,
    ERR
  } state_t;

  localparam logic [3:0] AMO_NONE = 4'd0;
  localparam logic [3:0] AMO_SWAP = 4'd1;
  localparam logic [3:0] AMO_ADD  = 4'd2;
  localparam logic [3:0] AMO_AND  = 4'd3;
  localparam logic [3:0] AMO_OR   = 4'd4;
  localparam logic [3:0] AMO_XOR  = 4'd5;
  localparam logic [3:0] AMO_MAXS = 4'd6;
  localparam logic [3:0] AMO_MINS = 4'd7;
  localparam logic [3:0] AMO_MAXU = 4'd8;
  localparam logic [3:0] AMO_MINU = 4'd9;

  function automatic logic amo_supported(
    input logic [3:0] tgc
  );
    return (tgc >= AMO_SWAP) && (tgc <= AMO_MINU);
  endfunction

endpackage

// File: rtl/fw_wishbone_amo_alu.sv
// Combinational AMO datapath: new memory value from old value and operand.
// Unknown opcodes leave memory as it was.
module fw_wishbone_amo_alu
  import fw_wishbone_sram_ctrl_pkg::*;
#(
  parameter int DAT_WIDTH = 32
) (
  input  logic [3:0]           op,
  input  logic [DAT_WIDTH-1:0] mem,
  input  logic [DAT_WIDTH-1:0] opnd,
  output logic [DAT_WIDTH-1:0] result
);

  logic gt_s;
  logic gt_u;

  assign gt_s = $signed(mem) > $signed(opnd);
  assign gt_u = mem > opnd;

  always_comb begin
    result = mem;
    unique case (op)
      AMO_SWAP: result = opnd;
      AMO_ADD:  result = mem + opnd;
      AMO_AND:  result = mem & opnd;
      AMO_OR:   result = mem | opnd;
      AMO_XOR:  result = mem ^ opnd;
      AMO_MAXS: result = gt_s ? mem : opnd;
      AMO_MINS: result = gt_s ? opnd : mem;
      AMO_MAXU: result = gt_u ? mem : opnd;
      AMO_MINU: result = gt_u ? opnd : mem;
      default:  result = mem;
    endcase
  end

endmodule

// File: rtl/fw_wishbone_sram_ctrl_amo.sv
// Wishbone classic target driving one byte-enabled synchronous SRAM,
// with range check, cycle abort and AMO read-modify-write.
module fw_wishbone_sram_ctrl_amo
  import fw_wishbone_sram_ctrl_pkg::*;
#(
  parameter int ADR_WIDTH  = 32,
  parameter int DAT_WIDTH  = 32,
  parameter int MEM_DEPTH  = 0,
  parameter int RD_LATENCY = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [ADR_WIDTH-1:0]   t_adr,
  input  logic [DAT_WIDTH-1:0]   t_dat_w,
  output logic [DAT_WIDTH-1:0]   t_dat_r,
  input  logic                   t_cyc,
  input  logic                   t_stb,
  input  logic                   t_we,
  input  logic [DAT_WIDTH/8-1:0] t_sel,
  input  logic [3:0]             t_tgc,
  output logic                   t_ack,
  output logic                   t_err,
  output logic [ADR_WIDTH-1:0]   i_addr,
  output logic                   i_read_en,
  output logic                   i_write_en,
  output logic [DAT_WIDTH/8-1:0] i_byte_en,
  output logic [DAT_WIDTH-1:0]   i_write_data,
  input  logic [DAT_WIDTH-1:0]   i_read_data
);

  localparam int SEL_W = DAT_WIDTH / 8;
  localparam int SHIFT = $clog2(SEL_W);

  state_t               state;
  logic [ADR_WIDTH-1:0] word_q;
  logic [DAT_WIDTH-1:0] dat_q;
  logic [SEL_W-1:0]     sel_q;
  logic [3:0]           tgc_q;
  logic                 cnt;
  logic [DAT_WIDTH-1:0] old_q;
  logic [DAT_WIDTH-1:0] new_q;
  logic [DAT_WIDTH-1:0] alu_result;

  logic [ADR_WIDTH-1:0] word_in;
  logic                 range_err;
  logic                 tgc_err;
  logic                 sel_err;
  logic                 req_err;

  assign word_in   = t_adr >> SHIFT;
  assign range_err = (MEM_DEPTH != 0) &&
                     (64'(word_in) >= 64'(MEM_DEPTH));
  assign tgc_err   = (t_tgc != AMO_NONE) && !amo_supported(t_tgc);
  assign sel_err   = (t_tgc != AMO_NONE) && (t_sel != '1);
  assign req_err   = range_err || tgc_err || sel_err;
  assign i_addr    = word_q;

  fw_wishbone_amo_alu #(
    .DAT_WIDTH(DAT_WIDTH)
  ) u_alu (
    .op    (tgc_q),
    .mem   (i_read_data),
    .opnd  (dat_q),
    .result(alu_result)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      word_q <= '0;
      dat_q  <= '0;
      sel_q  <= '0;
      tgc_q  <= '0;
      cnt    <= 1'b0;
      old_q  <= '0;
      new_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (t_cyc && t_stb) begin
            word_q <= word_in;
            dat_q  <= t_dat_w;
            sel_q  <= t_sel;
            tgc_q  <= t_tgc;
            if (req_err)                state <= ERR;
            else if (t_tgc != AMO_NONE) state <= READ;
            else if (t_we)              state <= WRITE;
            else                        state <= READ;
          end
        end
        READ: begin
          cnt   <= (RD_LATENCY > 1);
          state <= t_cyc ? RWAIT : IDLE;
        end
        RWAIT: begin
          if (!t_cyc) begin
            state <= IDLE;
          end else if (cnt) begin
            cnt <= 1'b0;
          end else if (tgc_q != AMO_NONE) begin
            old_q <= i_read_data;
            new_q <= alu_result;
            state <= AMO_WB;
          end else begin
            state <= IDLE;
          end
        end
        AMO_WB:  state <= IDLE;
        WRITE:   state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes and ack are gated by t_cyc so a dropped cycle aborts at once.
  always_comb begin
    t_ack        = 1'b0;
    t_err        = 1'b0;
    t_dat_r      = '0;
    i_read_en    = 1'b0;
    i_write_en   = 1'b0;
    i_byte_en    = '0;
    i_write_data = '0;
    unique case (state)
      READ: begin
        if (t_cyc) begin
          i_read_en = 1'b1;
          i_byte_en = '1;
        end
      end
      RWAIT: begin
        if (t_cyc && !cnt && tgc_q == AMO_NONE) begin
          t_ack   = 1'b1;
          t_dat_r = i_read_data;
        end
      end
      AMO_WB: begin
        if (t_cyc) begin
          i_write_en   = 1'b1;
          i_byte_en    = '1;
          i_write_data = new_q;
          t_ack        = 1'b1;
          t_dat_r      = old_q;
        end
      end
      WRITE: begin
        if (t_cyc) begin
          i_write_en   = 1'b1;
          i_byte_en    = sel_q;
          i_write_data = dat_q;
          t_ack        = 1'b1;
        end
      end
      ERR:     t_err = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fw_wishbone_sram_ctrl_amo.sv
// Randomized bench for the Wishbone SRAM controller against a word-array model.
// Two instances: 32-bit/latency 2/ranged and 64-bit/latency 1/unranged.
module tb_fw_wishbone_sram_ctrl_amo;
  import fw_wishbone_sram_ctrl_pkg::*;

  localparam int RDL   = 2;
  localparam int DEPTH = 256;

  logic clock;
  logic rst;

  logic [31:0] a_adr, a_dw, a_dr, a_iaddr, a_wd, a_rd;
  logic        a_cyc, a_stb, a_we, a_ack, a_err, a_ren, a_wen;
  logic [3:0]  a_sel, a_tgc, a_be;

  logic [31:0] b_adr, b_iaddr;
  logic [63:0] b_dw, b_dr, b_wd, b_rd;
  logic        b_cyc, b_stb, b_we, b_ack, b_err, b_ren, b_wen;
  logic [7:0]  b_sel, b_be;
  logic [3:0]  b_tgc;

  fw_wishbone_sram_ctrl_amo #(
    .ADR_WIDTH(32), .DAT_WIDTH(32),
    .MEM_DEPTH(DEPTH), .RD_LATENCY(RDL)
  ) dut_a (
    .clock(clock), .reset(rst),
    .t_adr(a_adr), .t_dat_w(a_dw), .t_dat_r(a_dr),
    .t_cyc(a_cyc), .t_stb(a_stb), .t_we(a_we),
    .t_sel(a_sel), .t_tgc(a_tgc),
    .t_ack(a_ack), .t_err(a_err),
    .i_addr(a_iaddr), .i_read_en(a_ren), .i_write_en(a_wen),
    .i_byte_en(a_be), .i_write_data(a_wd), .i_read_data(a_rd)
  );

  fw_wishbone_sram_ctrl_amo #(
    .ADR_WIDTH(32), .DAT_WIDTH(64),
    .MEM_DEPTH(0), .RD_LATENCY(1)
  ) dut_b (
    .clock(clock), .reset(rst),
    .t_adr(b_adr), .t_dat_w(b_dw), .t_dat_r(b_dr),
    .t_cyc(b_cyc), .t_stb(b_stb), .t_we(b_we),
    .t_sel(b_sel), .t_tgc(b_tgc),
    .t_ack(b_ack), .t_err(b_err),
    .i_addr(b_iaddr), .i_read_en(b_ren), .i_write_en(b_wen),
    .i_byte_en(b_be), .i_write_data(b_wd), .i_read_data(b_rd)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // SRAM macros: A has two read pipeline stages, B has one.
  logic [31:0] mem_a [DEPTH];
  logic [63:0] mem_b [64];
  logic [31:0] a_p1, a_p2;
  logic [63:0] b_p1;

  always @(posedge clock) begin
    for (int i = 0; i < 4; i++)
      if (a_wen && a_be[i])
        mem_a[a_iaddr[7:0]][i*8 +: 8] <= a_wd[i*8 +: 8];
    if (a_ren) a_p1 <= mem_a[a_iaddr[7:0]];
    a_p2 <= a_p1;
  end
  assign a_rd = a_p2;

  always @(posedge clock) begin
    for (int i = 0; i < 8; i++)
      if (b_wen && b_be[i])
        mem_b[b_iaddr[5:0]][i*8 +: 8] <= b_wd[i*8 +: 8];
    if (b_ren) b_p1 <= mem_b[b_iaddr[5:0]];
  end
  assign b_rd = b_p1;

  logic [31:0] ref_mem [DEPTH];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op,
                                          input logic [31:0] m,
                                          input logic [31:0] o);
    longint sm, so;
    sm = longint'($signed(m));
    so = longint'($signed(o));
    case (op)
      AMO_SWAP: return o;
      AMO_ADD:  return m + o;
      AMO_AND:  return m & o;
      AMO_OR:   return m | o;
      AMO_XOR:  return m ^ o;
      AMO_MAXS: return (sm > so) ? m : o;
      AMO_MINS: return (sm < so) ? m : o;
      AMO_MAXU: return (m > o) ? m : o;
      AMO_MINU: return (m < o) ? m : o;
      default:  return m;
    endcase
  endfunction

  // One Wishbone transfer; latency counts cycles after the request cycle.
  task automatic xfer(input bit b, input logic [31:0] adr,
                      input logic [63:0] dat, input logic [7:0] sel,
                      input logic we, input logic [3:0] tgc,
                      output int kind, output int lat,
                      output logic [63:0] rdata, output bit strobed,
                      output bit both, output logic [31:0] addr,
                      output logic [7:0] be);
    bit ack, err;
    @(negedge clock);
    if (b) begin
      b_adr = adr; b_dw = dat; b_sel = sel;
      b_we = we; b_tgc = tgc; b_cyc = 1; b_stb = 1;
    end else begin
      a_adr = adr; a_dw = dat[31:0]; a_sel = sel[3:0];
      a_we = we; a_tgc = tgc; a_cyc = 1; a_stb = 1;
    end
    kind = 0; lat = 0; rdata = '0; strobed = 0;
    both = 0; addr = '0; be = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      ack = b ? b_ack : a_ack;
      err = b ? b_err : a_err;
      if (b ? (b_ren | b_wen) : (a_ren | a_wen)) strobed = 1;
      if (ack && err) both = 1;
      if (ack || err) begin
        kind  = ack ? 1 : 2;
        lat   = c;
        rdata = b ? b_dr : 64'(a_dr);
        addr  = b ? b_iaddr : a_iaddr;
        be    = b ? b_be : 8'(a_be);
        break;
      end
    end
    @(posedge clock);
    #1;
    a_cyc = 0; a_stb = 0; b_cyc = 0; b_stb = 0;
  endtask

  // Model-checked transfer on the 32-bit instance.
  task automatic txn(input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, input logic we,
                     input logic [3:0] tgc, output logic [31:0] rd);
    int w, ek, el, k, l;
    bit e, cd, st, bo;
    logic [31:0] ed, ad;
    logic [63:0] r;
    logic [7:0] be;
    w  = int'(adr >> 2);
    e  = (w >= DEPTH) || (tgc > AMO_MINU) ||
         (tgc != 0 && sel != 4'hF);
    cd = 0;
    ed = '0;
    if (e) begin
      ek = 2; el = 1;
    end else if (tgc != 0) begin
      ek = 1; el = 2 + RDL; ed = ref_mem[w]; cd = 1;
      ref_mem[w] = ref_alu(tgc, ref_mem[w], dat);
    end else if (we) begin
      ek = 1; el = 1;
      for (int i = 0; i < 4; i++)
        if (sel[i]) ref_mem[w][i*8 +: 8] = dat[i*8 +: 8];
    end else begin
      ek = 1; el = 1 + RDL; ed = ref_mem[w]; cd = 1;
    end
    xfer(0, adr, 64'(dat), 8'(sel), we, tgc, k, l, r, st, bo, ad, be);
    chk($sformatf("kind@%h", adr), 64'(k), 64'(ek));
    chk($sformatf("lat@%h", adr), 64'(l), 64'(el));
    chk("ack_err_excl", 64'(bo), 64'd0);
    if (cd) chk($sformatf("rdata@%h", adr), r, 64'(ed));
    if (e) chk("err_no_strobe", 64'(st), 64'd0);
    else chk($sformatf("mem@%h", adr), 64'(mem_a[w]), 64'(ref_mem[w]));
    @(negedge clock);
    chk("term_one_cycle", 64'(a_ack | a_err), 64'd0);
    rd = r[31:0];
  endtask

  int          k, l, r;
  bit          st, bo;
  logic [63:0] rv;
  logic [31:0] ad, rd, adr, dat;
  logic [7:0]  be;
  logic [3:0]  sel, tgc;
  logic        we;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_a[i] = '0; ref_mem[i] = '0;
    end
    for (int i = 0; i < 64; i++) mem_b[i] = '0;
    a_p1 = '0; a_p2 = '0; b_p1 = '0;
    a_adr = '0; a_dw = '0; a_cyc = 0; a_stb = 0;
    a_we = 0; a_sel = '0; a_tgc = '0;
    b_adr = '0; b_dw = '0; b_cyc = 0; b_stb = 0;
    b_we = 0; b_sel = '0; b_tgc = '0;
    rst = 1;
    repeat (2) @(negedge clock);
    chk("rst_ack", 64'(a_ack | a_err), 64'd0);
    chk("rst_strobe", 64'({a_ren, a_wen, a_be}), 64'd0);
    chk("rst_addr", 64'(a_iaddr), 64'd0);
    chk("rst_dat_r", 64'(a_dr), 64'd0);
    rst = 0;

    txn(32'h10, 32'hDEADBEEF, 4'b0011, 1, AMO_NONE, rd);
    txn(32'h10, 32'h0, 4'hF, 0, AMO_NONE, rd);
    chk("beef_read", 64'(rd), 64'h0000BEEF);

    txn(32'h20, 32'hFFFFFFFF, 4'hF, 1, AMO_NONE, rd);
    txn(32'h20, 32'h1, 4'hF, 0, AMO_ADD, rd);
    chk("add_old", 64'(rd), 64'hFFFFFFFF);
    chk("add_wrap", 64'(mem_a[8]), 64'h0);

    txn(32'h30, 32'h80000000, 4'hF, 1, AMO_NONE, rd);
    txn(32'h30, 32'h1, 4'hF, 0, AMO_MAXS, rd);
    chk("maxs_old", 64'(rd), 64'h80000000);
    chk("maxs_mem", 64'(mem_a[12]), 64'h1);
    txn(32'h30, 32'h80000000, 4'hF, 1, AMO_NONE, rd);
    txn(32'h30, 32'h1, 4'hF, 0, AMO_MAXU, rd);
    chk("maxu_old", 64'(rd), 64'h80000000);
    chk("maxu_mem", 64'(mem_a[12]), 64'h80000000);

    txn(32'h400, 32'h5, 4'hF, 0, AMO_NONE, rd);
    txn(32'h40, 32'h5, 4'hF, 0, 4'd15, rd);
    txn(32'h40, 32'h5, 4'b0001, 0, AMO_ADD, rd);

    // Abort an AMO during its read wait.
    txn(32'h50, 32'hCAFEF00D, 4'hF, 1, AMO_NONE, rd);
    @(negedge clock);
    a_adr = 32'h50; a_dw = 32'h12345678; a_sel = 4'hF;
    a_we = 0; a_tgc = AMO_SWAP; a_cyc = 1; a_stb = 1;
    repeat (2) @(negedge clock);
    st = a_ack | a_wen;
    a_cyc = 0; a_stb = 0;
    #1;
    st = st | a_ack | a_wen;
    @(negedge clock);
    st = st | a_ack | a_wen | a_ren;
    chk("abort_quiet", 64'(st), 64'd0);
    txn(32'h54, 32'h11223344, 4'hF, 1, AMO_NONE, rd);
    chk("abort_mem", 64'(mem_a[20]), 64'hCAFEF00D);

    // Reset while the AMO write-back is on the bus.
    txn(32'h58, 32'h00000007, 4'hF, 1, AMO_NONE, rd);
    @(negedge clock);
    a_adr = 32'h58; a_dw = 32'h5; a_sel = 4'hF;
    a_we = 0; a_tgc = AMO_ADD; a_cyc = 1; a_stb = 1;
    repeat (2 + RDL) @(negedge clock);
    chk("amo_wb_ack", 64'(a_ack), 64'd1);
    rst = 1;
    #1;
    chk("rst_mid_ack", 64'(a_ack), 64'd0);
    chk("rst_mid_wen", 64'(a_wen), 64'd0);
    chk("rst_mid_dat", 64'(a_dr), 64'd0);
    chk("rst_mid_addr", 64'(a_iaddr), 64'd0);
    @(posedge clock);
    #1;
    a_cyc = 0; a_stb = 0;
    rst = 0;
    chk("rst_mid_mem", 64'(mem_a[22]), 64'h7);

    for (int n = 0; n < 150; n++) begin
      r   = $urandom_range(0, 9);
      adr = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      dat = $urandom;
      sel = 4'($urandom_range(0, 15));
      we  = 1'($urandom_range(0, 1));
      tgc = AMO_NONE;
      if (r <= 2) we = 1;
      else if (r <= 4) we = 0;
      else if (r <= 7) begin
        tgc = 4'($urandom_range(1, 9)); sel = 4'hF;
      end else if (r == 8) tgc = 4'($urandom_range(10, 15));
      else begin
        tgc = 4'($urandom_range(1, 9));
        sel = 4'($urandom_range(0, 14));
      end
      if ($urandom_range(0, 9) == 0)
        adr = $urandom_range(256, 1023) << 2;
      txn(adr, dat, sel, we, tgc, rd);
    end
    for (int w = 0; w < 16; w++)
      chk($sformatf("sweep%0d", w), 64'(mem_a[w]), 64'(ref_mem[w]));

    // 64-bit instance, read latency 1, no range check.
    xfer(1, 32'h18, 64'h0123456789ABCDEF, 8'hFF, 1, AMO_NONE,
         k, l, rv, st, bo, ad, be);
    chk("b_wr_kind", 64'(k), 64'd1);
    chk("b_wr_lat", 64'(l), 64'd1);
    chk("b_wr_addr", 64'(ad), 64'd3);
    chk("b_wr_be", 64'(be), 64'hFF);
    chk("b_wr_mem", mem_b[3], 64'h0123456789ABCDEF);
    xfer(1, 32'h18, 64'h0, 8'hFF, 0, AMO_NONE, k, l, rv, st, bo, ad, be);
    chk("b_rd_lat", 64'(l), 64'd2);
    chk("b_rd_data", rv, 64'h0123456789ABCDEF);
    xfer(1, 32'h18, 64'h1, 8'hFF, 0, AMO_ADD, k, l, rv, st, bo, ad, be);
    chk("b_add_lat", 64'(l), 64'd3);
    chk("b_add_old", rv, 64'h0123456789ABCDEF);
    chk("b_add_mem", mem_b[3], 64'h0123456789ABCDF0);
    xfer(1, 32'h20, 64'h8000000000000000, 8'hFF, 1, AMO_NONE,
         k, l, rv, st, bo, ad, be);
    xfer(1, 32'h20, 64'h5, 8'hFF, 0, AMO_MINS, k, l, rv, st, bo, ad, be);
    chk("b_mins_old", rv, 64'h8000000000000000);
    chk("b_mins_mem", mem_b[4], 64'h8000000000000000);
    xfer(1, 32'h20, 64'h5, 8'hFF, 0, AMO_MAXS, k, l, rv, st, bo, ad, be);
    chk("b_maxs_mem", mem_b[4], 64'h5);
    xfer(1, 32'h0010_0000, 64'hAA, 8'h0F, 1, AMO_NONE,
         k, l, rv, st, bo, ad, be);
    chk("b_norange_kind", 64'(k), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
